// File: rtl/ram_dp_slave.sv
// True dual-port synchronous RAM, slave side, with read pipeline,
// read-first collision rules and a post-reset clear sweep.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   addra/dina/wea/rea  : port A request
//   douta/dvala         : port A read data / one-cycle valid
//   addrb/dinb/web/reb  : port B request
//   doutb/dvalb         : port B read data / one-cycle valid
//   busy                : clear sweep in progress, requests ignored
module ram_dp_slave #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  wea,
  input  logic                  rea,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  dvala,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  input  logic                  web,
  input  logic                  reb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  dvalb,
  output logic                  busy
);

  localparam int L = READ_LATENCY;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("READ_LATENCY must be in 1..4");
  end

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc;
  logic                    ina;
  logic                    inb;
  logic                    rd_a;
  logic                    rd_b;
  logic                    wr_a;
  logic                    wr_b;
  logic                    clearing;
  logic [DATA_WIDTH-1:0]   rdat_a;
  logic [DATA_WIDTH-1:0]   rdat_b;

  logic [L-1:0]            va;
  logic [L-1:0]            vb;
  logic [DATA_WIDTH-1:0]   da [L];
  logic [DATA_WIDTH-1:0]   db [L];

  // With a power-of-two depth every address is in range.
  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_pow2
    assign ina = 1'b1;
    assign inb = 1'b1;
  end else begin : g_npow2
    assign ina = (32'(addra) < DEPTH);
    assign inb = (32'(addrb) < DEPTH);
  end

  assign acc      = (state == READY) && !rst;
  assign clearing = (state == CLEAR) && !rst;
  assign rd_a     = acc && rea;
  assign rd_b     = acc && reb;
  assign wr_a     = acc && wea && ina;
  assign wr_b     = acc && web && inb;

  // Sampled before this edge's writes land: read-first.
  assign rdat_a = ina ? mem[addra] : '0;
  assign rdat_b = inb ? mem[addrb] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state <= CLEAR;
        busy  <= 1'b1;
      end else begin
        state <= READY;
        busy  <= 1'b0;
      end
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          busy <= 1'b0;
        end
        default: begin
          state <= READY;
        end
      endcase
    end
  end

  // Port A written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr_b) mem[addrb] <= dinb;
      if (wr_a) mem[addra] <= dina;
    end
  end

  // Data stages only load on valid, so dout holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      va <= '0;
      vb <= '0;
      for (int k = 0; k < L; k++) begin
        da[k] <= '0;
        db[k] <= '0;
      end
    end else begin
      va[0] <= rd_a;
      vb[0] <= rd_b;
      if (rd_a) da[0] <= rdat_a;
      if (rd_b) db[0] <= rdat_b;
      for (int k = 1; k < L; k++) begin
        va[k] <= va[k-1];
        vb[k] <= vb[k-1];
        if (va[k-1]) da[k] <= da[k-1];
        if (vb[k-1]) db[k] <= db[k-1];
      end
    end
  end

  assign douta = da[L-1];
  assign doutb = db[L-1];
  assign dvala = va[L-1];
  assign dvalb = vb[L-1];

endmodule

// File: tb/tb_ram_dp_slave.sv
// Scoreboard bench for ram_dp_slave: four instances with
// READ_LATENCY 1..4 (the L=3 one has DEPTH=12) share stimulus.
module tb_ram_dp_slave;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] addra = '0;
  logic [7:0] dina = '0;
  logic       wea = 1'b0;
  logic       rea = 1'b0;
  logic [3:0] addrb = '0;
  logic [7:0] dinb = '0;
  logic       web = 1'b0;
  logic       reb = 1'b0;

  logic [7:0] dout_a [4];
  logic [7:0] dout_b [4];
  logic       dval_a [4];
  logic       dval_b [4];
  logic       busy   [4];

  exp_t q [8][$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    return k + 1;
  endfunction

  function automatic int dep(input int k);
    return (k == 2) ? 12 : 16;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    ram_dp_slave #(
      .DATA_WIDTH(8),
      .DEPTH(dep(k)),
      .READ_LATENCY(k + 1),
      .CLEAR_ON_RESET(1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .addra(addra),
      .dina(dina),
      .wea(wea),
      .rea(rea),
      .douta(dout_a[k]),
      .dvala(dval_a[k]),
      .addrb(addrb),
      .dinb(dinb),
      .web(web),
      .reb(reb),
      .doutb(dout_b[k]),
      .dvalb(dval_b[k]),
      .busy(busy[k])
    );
  end

  task automatic chk_rd(input int idx, input logic v,
                        input logic [7:0] d);
    exp_t e;
    if (v) begin
      checks++;
      if (q[idx].size() == 0) begin
        errors++;
        $display("FAIL stray_dval idx=%0d cyc=%0d got=%h required=none",
                 idx, cyc, d);
      end else begin
        e = q[idx].pop_front();
        if (d !== e.d || cyc != e.c) begin
          errors++;
          $display("FAIL read idx=%0d got d=%h cyc=%0d required d=%h cyc=%0d",
                   idx, d, cyc, e.d, e.c);
        end
      end
    end else if (q[idx].size() > 0 && cyc > q[idx][0].c) begin
      checks++;
      errors++;
      e = q[idx].pop_front();
      $display("FAIL missing_dval idx=%0d cyc=%0d required d=%h cyc=%0d",
               idx, cyc, e.d, e.c);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_mon
    always @(negedge clk) begin
      chk_rd(2 * k, dval_a[k], dout_a[k]);
      chk_rd(2 * k + 1, dval_b[k], dout_b[k]);
    end
  end

  task automatic chk_eq(input string name, input int got,
                        input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic op(
    input logic       wa, input logic ra,
    input logic [3:0] aa, input logic [7:0] dia,
    input logic       wb, input logic rb,
    input logic [3:0] ab, input logic [7:0] dib,
    input logic [7:0] ea16, input logic [7:0] ea12,
    input logic [7:0] eb16, input logic [7:0] eb12
  );
    exp_t e;
    wea = wa; rea = ra; addra = aa; dina = dia;
    web = wb; reb = rb; addrb = ab; dinb = dib;
    for (int k = 0; k < 4; k++) begin
      e.c = cyc + lat(k);
      if (ra) begin
        e.d = (dep(k) == 12) ? ea12 : ea16;
        q[2 * k].push_back(e);
      end
      if (rb) begin
        e.d = (dep(k) == 12) ? eb12 : eb16;
        q[2 * k + 1].push_back(e);
      end
    end
    tick();
    wea = 1'b0; rea = 1'b0; web = 1'b0; reb = 1'b0;
  endtask

  task automatic wait_clear(input bit poke);
    int cnt [4];
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++)
        if (busy[k]) cnt[k]++;
      if (poke && i == 0) begin
        wea = 1'b1; rea = 1'b1; addra = 4'd2; dina = 8'hEE;
        reb = 1'b1; addrb = 4'd2;
      end
      tick();
      wea = 1'b0; rea = 1'b0; reb = 1'b0;
    end
    for (int k = 0; k < 4; k++)
      chk_eq($sformatf("busy_len%0d", k), cnt[k], dep(k));
  endtask

  initial begin
    logic [7:0] v;
    idle(3);
    for (int k = 0; k < 4; k++) begin
      chk_eq($sformatf("rst_dval%0d", k), int'(dval_a[k]), 0);
      chk_eq($sformatf("rst_dout%0d", k), int'(dout_b[k]), 0);
      chk_eq($sformatf("rst_busy%0d", k), int'(busy[k]), 1);
    end
    rst = 1'b0;
    wait_clear(1'b1);

    for (int i = 0; i < 16; i++)
      op(0, 1, 4'(i), 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);

    op(1, 0, 4'd3, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0);
    op(0, 1, 4'd3, 0, 0, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
    idle(6);
    for (int k = 0; k < 4; k++) begin
      chk_eq($sformatf("hold_a%0d", k), int'(dout_a[k]), 'hA5);
      chk_eq($sformatf("hold_v%0d", k), int'(dval_a[k]), 0);
    end

    op(1, 0, 4'd5, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    op(0, 1, 4'd5, 0, 1, 0, 4'd5, 8'h22, 8'h11, 8'h11, 0, 0);
    op(0, 1, 4'd5, 0, 0, 0, 0, 0, 8'h22, 8'h22, 0, 0);

    op(1, 0, 4'd7, 8'h33, 1, 0, 4'd7, 8'h44, 0, 0, 0, 0);
    op(0, 1, 4'd7, 0, 0, 1, 4'd7, 0, 8'h33, 8'h33, 8'h33, 8'h33);

    op(1, 1, 4'd9, 8'h5A, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    op(0, 1, 4'd9, 0, 0, 0, 0, 0, 8'h5A, 8'h5A, 0, 0);

    for (int i = 0; i < 16; i++)
      op(1, 0, 4'(i), 8'hC0 | 8'(i), 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      v = 8'hC0 | 8'(i);
      op(0, 0, 0, 0, 0, 1, 4'(i), 0, 0, 0, v, (i < 12) ? v : 8'h00);
    end
    idle(6);
    for (int k = 0; k < 4; k++) begin
      chk_eq($sformatf("hold_b%0d", k), int'(dout_b[k]),
             (dep(k) == 12) ? 0 : 'hCF);
      chk_eq($sformatf("hold_vb%0d", k), int'(dval_b[k]), 0);
    end

    op(0, 1, 4'd1, 0, 0, 1, 4'd2, 0, 8'hC1, 8'hC1, 8'hC2, 8'hC2);
    rst = 1'b1;
    for (int i = 2; i < 8; i++) q[i].delete();
    tick();
    rst = 1'b0;
    idle(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(1'b0);

    op(0, 1, 4'd5, 0, 0, 1, 4'd3, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(8);
    for (int i = 0; i < 8; i++)
      chk_eq($sformatf("q_empty%0d", i), q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
